// File: rtl/ysyx_22050133_axi_arbiter_pkg.sv
// Shared encodings for the ysyx_22050133 AXI arbiter: FSM states, command field layout,
// AXI size codes and small command-field helpers.
package ysyx_22050133_axi_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_e;

    // Command word: {we[11], size[10:8], len[7:0]}
    localparam int unsigned CMD_W        = 12;
    localparam int unsigned CMD_WE_BIT   = 11;
    localparam int unsigned CMD_SIZE_MSB = 10;
    localparam int unsigned CMD_SIZE_LSB = 8;
    localparam int unsigned CMD_LEN_MSB  = 7;
    localparam int unsigned CMD_LEN_LSB  = 0;

    localparam logic [2:0] AXI_SIZE_BYTES_1 = 3'b000;
    localparam logic [2:0] AXI_SIZE_BYTES_2 = 3'b001;
    localparam logic [2:0] AXI_SIZE_BYTES_4 = 3'b010;
    localparam logic [2:0] AXI_SIZE_BYTES_8 = 3'b011;

    function automatic logic cmd_we(input logic [CMD_W-1:0] cmd);
        return cmd[CMD_WE_BIT];
    endfunction

    function automatic logic [7:0] cmd_len(input logic [CMD_W-1:0] cmd);
        return cmd[CMD_LEN_MSB:CMD_LEN_LSB];
    endfunction

endpackage

// File: rtl/ysyx_22050133_arb_pick.sv
// Winner select for the two-port arbiter. YSYX_22050133_ARB_RR_EN selects round-robin on ties;
// otherwise port 1 (dcache) has fixed priority and last_gnt is ignored.
module ysyx_22050133_arb_pick (
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       win
);

`ifdef YSYX_22050133_ARB_RR_EN
    always_comb begin
        if (&req) win = ~last_gnt;
        else      win = req[1];
    end
`else
    logic unused_last_gnt;
    assign unused_last_gnt = last_gnt;

    always_comb win = req[1];
`endif

endmodule

// File: rtl/ysyx_22050133_axi_arbiter.sv
// Two-requester (icache/dcache) to one-master AXI-like arbiter with a single outstanding burst.
// Define YSYX_22050133_ARB_RR_EN for round-robin tie-breaking instead of fixed dcache priority.
module ysyx_22050133_axi_arbiter
    import ysyx_22050133_axi_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              s_addr_valid_i,
    output logic [1:0]              s_addr_ready_o,
    input  logic [2*ADDR_WIDTH-1:0] s_addr_i,
    input  logic [2*CMD_W-1:0]      s_cmd_i,
    input  logic [1:0]              s_w_valid_i,
    output logic [1:0]              s_w_ready_o,
    input  logic [2*DATA_WIDTH-1:0] s_w_data_i,
    output logic [1:0]              s_r_valid_o,
    input  logic [1:0]              s_r_ready_i,
    output logic [DATA_WIDTH-1:0]   s_r_data_o,
    output logic                    m_addr_valid_o,
    input  logic                    m_addr_ready_i,
    output logic [ADDR_WIDTH-1:0]   m_addr_o,
    output logic [CMD_W-1:0]        m_cmd_o,
    output logic                    m_w_valid_o,
    input  logic                    m_w_ready_i,
    output logic [DATA_WIDTH-1:0]   m_w_data_o,
    input  logic                    m_r_valid_i,
    output logic                    m_r_ready_o,
    input  logic [DATA_WIDTH-1:0]   m_r_data_i
);

    arb_state_e            state, state_nxt;
    logic                  gnt;
    logic [7:0]            cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CMD_W-1:0]      cmd_q;
    logic                  last_gnt;
    logic                  pick;
    logic                  grant, addr_hs, beat_hs;
    logic                  wr_q;

    ysyx_22050133_arb_pick u_pick (
        .req      (s_addr_valid_i),
        .last_gnt (last_gnt),
        .win      (pick)
    );

`ifdef YSYX_22050133_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (rst)        last_gnt <= 1'b1;
        else if (grant) last_gnt <= pick;
    end
`else
    assign last_gnt = 1'b1;
`endif

    assign wr_q = cmd_we(cmd_q);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt    <= 1'b0;
            cnt    <= '0;
            addr_q <= '0;
            cmd_q  <= '0;
        end else begin
            if (grant) begin
                gnt    <= pick;
                addr_q <= pick ? s_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : s_addr_i[ADDR_WIDTH-1:0];
                cmd_q  <= pick ? s_cmd_i[2*CMD_W-1:CMD_W] : s_cmd_i[CMD_W-1:0];
            end
            if (addr_hs)                   cnt <= cmd_len(cmd_q);
            else if (beat_hs && cnt != '0) cnt <= cnt - 8'd1;
        end
    end

    // Outputs are gated by rst so they read zero during the reset cycle itself.
    always_comb begin
        state_nxt      = state;
        grant          = 1'b0;
        addr_hs        = 1'b0;
        beat_hs        = 1'b0;
        s_addr_ready_o = '0;
        s_w_ready_o    = '0;
        s_r_valid_o    = '0;
        s_r_data_o     = '0;
        m_addr_valid_o = 1'b0;
        m_addr_o       = '0;
        m_cmd_o        = '0;
        m_w_valid_o    = 1'b0;
        m_w_data_o     = '0;
        m_r_ready_o    = 1'b0;
        if (!rst) begin
            s_r_data_o = m_r_data_i;
            case (state)
                ST_IDLE: begin
                    if (|s_addr_valid_i) begin
                        grant                = 1'b1;
                        s_addr_ready_o[pick] = 1'b1;
                        state_nxt            = ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    m_addr_valid_o = 1'b1;
                    m_addr_o       = addr_q;
                    m_cmd_o        = cmd_q;
                    if (m_addr_ready_i) begin
                        addr_hs   = 1'b1;
                        state_nxt = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (wr_q) begin
                        m_w_valid_o      = s_w_valid_i[gnt];
                        s_w_ready_o[gnt] = m_w_ready_i;
                        m_w_data_o       = gnt ? s_w_data_i[2*DATA_WIDTH-1:DATA_WIDTH]
                                               : s_w_data_i[DATA_WIDTH-1:0];
                        beat_hs          = s_w_valid_i[gnt] & m_w_ready_i;
                    end else begin
                        s_r_valid_o[gnt] = m_r_valid_i;
                        m_r_ready_o      = s_r_ready_i[gnt];
                        beat_hs          = m_r_valid_i & s_r_ready_i[gnt];
                    end
                    if (beat_hs && cnt == '0) state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22050133_axi_arbiter.sv
// Self-checking bench for ysyx_22050133_axi_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of grant order, forwarded commands and beat data.
module tb_ysyx_22050133_axi_arbiter;

    localparam int DW = 64;
    localparam int AW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      s_addr_valid_i;
    logic [1:0]      s_addr_ready_o;
    logic [2*AW-1:0] s_addr_i;
    logic [23:0]     s_cmd_i;
    logic [1:0]      s_w_valid_i;
    logic [1:0]      s_w_ready_o;
    logic [2*DW-1:0] s_w_data_i;
    logic [1:0]      s_r_valid_o;
    logic [1:0]      s_r_ready_i;
    logic [DW-1:0]   s_r_data_o;
    logic            m_addr_valid_o;
    logic            m_addr_ready_i;
    logic [AW-1:0]   m_addr_o;
    logic [11:0]     m_cmd_o;
    logic            m_w_valid_o;
    logic            m_w_ready_i;
    logic [DW-1:0]   m_w_data_o;
    logic            m_r_valid_i;
    logic            m_r_ready_o;
    logic [DW-1:0]   m_r_data_i;

    always #5 clk = ~clk;

    ysyx_22050133_axi_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .s_addr_valid_i(s_addr_valid_i), .s_addr_ready_o(s_addr_ready_o),
        .s_addr_i(s_addr_i), .s_cmd_i(s_cmd_i),
        .s_w_valid_i(s_w_valid_i), .s_w_ready_o(s_w_ready_o), .s_w_data_i(s_w_data_i),
        .s_r_valid_o(s_r_valid_o), .s_r_ready_i(s_r_ready_i), .s_r_data_o(s_r_data_o),
        .m_addr_valid_o(m_addr_valid_o), .m_addr_ready_i(m_addr_ready_i),
        .m_addr_o(m_addr_o), .m_cmd_o(m_cmd_o),
        .m_w_valid_o(m_w_valid_o), .m_w_ready_i(m_w_ready_i), .m_w_data_o(m_w_data_o),
        .m_r_valid_i(m_r_valid_i), .m_r_ready_o(m_r_ready_o), .m_r_data_i(m_r_data_i)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: pending requests per port and the last granted port.
    logic [1:0]    pend;
    logic          model_last;
    logic [AW-1:0] p_addr [2];
    logic [11:0]   p_cmd  [2];
    logic [63:0]   p_data [2][8];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_pick(input logic [1:0] p);
        if (p == 2'b11) begin
`ifdef YSYX_22050133_ARB_RR_EN
            return model_last ? 0 : 1;
`else
            return 1;
`endif
        end
        return p[1] ? 1 : 0;
    endfunction

    task automatic new_req(input int port, input logic we, input logic [AW-1:0] addr, input int len);
        p_addr[port] = addr;
        p_cmd[port]  = {we, 3'b011, 8'(len)};
        for (int i = 0; i < 8; i++) p_data[port][i] = {$urandom, $urandom};
        pend[port] = 1'b1;
    endtask

    task automatic drive_req_bus();
        s_addr_valid_i = pend;
        s_addr_i = {pend[1] ? p_addr[1] : AW'($urandom), pend[0] ? p_addr[0] : AW'($urandom)};
        s_cmd_i  = {pend[1] ? p_cmd[1] : 12'($urandom), pend[0] ? p_cmd[0] : 12'($urandom)};
    endtask

    task automatic quiet_data();
        s_w_valid_i = '0; s_r_ready_i = '0; m_w_ready_i = 1'b0; m_r_valid_i = 1'b0;
        m_addr_ready_i = 1'b0;
    endtask

    // An idle cycle with no requests: everything handshake-related must stay low.
    task automatic idle_check();
        drive_req_bus();
        s_w_valid_i = 2'b11; m_w_ready_i = 1'b1; m_r_valid_i = 1'b1; s_r_ready_i = 2'b11;
        #1;
        check("idle_addr_ready", s_addr_ready_o, 2'b00);
        check("idle_m_addr_valid", m_addr_valid_o, 1'b0);
        check("idle_m_w_valid", m_w_valid_o, 1'b0);
        check("idle_s_r_valid", s_r_valid_o, 2'b00);
        check("idle_m_r_ready", m_r_ready_o, 1'b0);
        tick();
        quiet_data();
    endtask

    // Starts at the drive point of an IDLE cycle with at least one pending request.
    task automatic run_txn(input bit tog, input int rst_beat, input int stall_in);
        int            win, len, beat, cyc, stall;
        logic          we, hs;
        logic [AW-1:0] ea;
        logic [11:0]   ec;
        logic [63:0]   d [8];
        logic [1:0]    oh;
        bit            aborted;

        win = model_pick(pend);
        oh  = (win == 1) ? 2'b10 : 2'b01;
        ea  = p_addr[win];
        ec  = p_cmd[win];
        we  = ec[11];
        len = int'(ec[7:0]);
        for (int i = 0; i < 8; i++) d[i] = p_data[win][i];

        quiet_data();
        drive_req_bus();
        #1;
        check("grant_onehot", s_addr_ready_o, oh);
        check("grant_no_m_valid", m_addr_valid_o, 1'b0);
        pend[win]  = 1'b0;
        model_last = oh[1];
        tick();

        // Winner withdraws and scrambles its request; the latched copy must be unaffected.
        drive_req_bus();
        stall = (stall_in < 0) ? $urandom_range(0, 3) : stall_in;
        for (int k = 0; k <= stall; k++) begin
            m_addr_ready_i = (k == stall);
            #1;
            check("addr_valid", m_addr_valid_o, 1'b1);
            check("addr_value", m_addr_o, ea);
            check("addr_cmd", m_cmd_o, ec);
            check("addr_phase_ready", s_addr_ready_o, 2'b00);
            tick();
            drive_req_bus();
        end
        m_addr_ready_i = 1'b0;

        beat = 0; cyc = 0; aborted = 0;
        while (beat <= len && cyc < 300 && !aborted) begin
            s_w_valid_i = 2'($urandom);
            s_w_valid_i[win] = ($urandom_range(0, 3) != 0);
            s_w_data_i  = {$urandom, $urandom, $urandom, $urandom};
            if (win == 1) s_w_data_i[2*DW-1:DW] = d[beat];
            else          s_w_data_i[DW-1:0]    = d[beat];
            m_w_ready_i = tog ? (cyc % 2 == 1) : ($urandom_range(0, 3) != 0);
            m_r_valid_i = ($urandom_range(0, 3) != 0);
            m_r_data_i  = d[beat];
            s_r_ready_i = 2'($urandom);
            s_r_ready_i[win] = ($urandom_range(0, 3) != 0);
            if (!we && beat == rst_beat) begin
                rst = 1'b1; m_r_valid_i = 1'b1; s_r_ready_i = 2'b11;
                #1;
                check("rst_s_r_valid", s_r_valid_o, 2'b00);
                check("rst_m_r_ready", m_r_ready_o, 1'b0);
                check("rst_s_r_data", s_r_data_o, 64'd0);
                check("rst_addr_ready", s_addr_ready_o, 2'b00);
                check("rst_m_addr", {m_addr_valid_o, m_addr_o, m_cmd_o}, 64'd0);
                check("rst_w_side", {m_w_valid_o, s_w_ready_o}, 64'd0);
                tick();
                rst = 1'b0; pend = '0; model_last = 1'b1;
                drive_req_bus();
                #1;
                check("post_rst_s_r_valid", s_r_valid_o, 2'b00);
                check("post_rst_m_r_ready", m_r_ready_o, 1'b0);
                check("post_rst_m_addr_valid", m_addr_valid_o, 1'b0);
                tick();
                aborted = 1;
            end else begin
                #1;
                check("data_no_addr_valid", m_addr_valid_o, 1'b0);
                check("data_no_grant", s_addr_ready_o, 2'b00);
                if (we) begin
                    check("wr_m_w_valid", m_w_valid_o, s_w_valid_i[win]);
                    check("wr_s_w_ready", s_w_ready_o, m_w_ready_i ? oh : 2'b00);
                    check("wr_read_idle", {m_r_ready_o, s_r_valid_o}, 64'd0);
                    hs = s_w_valid_i[win] && m_w_ready_i;
                    if (hs) check("wr_data", m_w_data_o, d[beat]);
                end else begin
                    check("rd_s_r_valid", s_r_valid_o, m_r_valid_i ? oh : 2'b00);
                    check("rd_m_r_ready", m_r_ready_o, s_r_ready_i[win]);
                    check("rd_write_idle", {m_w_valid_o, s_w_ready_o}, 64'd0);
                    hs = m_r_valid_i && s_r_ready_i[win];
                    if (hs) check("rd_data", s_r_data_o, d[beat]);
                end
                if (hs) beat++;
                tick();
                drive_req_bus();
                cyc++;
            end
        end
        if (!aborted) check("beat_count", beat, len + 1);
        quiet_data();
    endtask

    initial begin
        rst = 1'b1; pend = '0; model_last = 1'b1;
        quiet_data();
        s_addr_valid_i = '0; s_addr_i = '0; s_cmd_i = '0; s_w_data_i = '0;
        m_r_data_i = 64'hdead_beef_0123_4567;
        tick(); tick();
        #1;
        check("reset_addr_ready", s_addr_ready_o, 2'b00);
        check("reset_m_addr_valid", m_addr_valid_o, 1'b0);
        check("reset_m_addr_cmd", {m_addr_o, m_cmd_o}, 64'd0);
        check("reset_s_r_data", s_r_data_o, 64'd0);
        rst = 1'b0;
        tick();

        // Port 0 read burst of 8 beats.
        new_req(0, 1'b0, 32'h8000_0040, 7);
        run_txn(0, -1, -1);
        idle_check();

        // Simultaneous requests: winner follows the arbitration rule, loser after one idle cycle.
        new_req(0, 1'b0, 32'h8000_1000, 3);
        new_req(1, 1'b1, 32'h8000_2000, 2);
        run_txn(0, -1, -1);
        run_txn(0, -1, -1);
        idle_check();

        // Address stalled for 5 cycles.
        new_req(0, 1'b1, 32'h8000_3008, 1);
        run_txn(0, -1, 5);
        idle_check();

        // Port 1 write, 8 beats, downstream ready toggling.
        new_req(1, 1'b1, 32'h8000_4000, 7);
        run_txn(1, -1, 0);
        idle_check();

        // Reset during beat 3 of an 8-beat read, then a normal port 0 request.
        new_req(0, 1'b0, 32'h8000_5000, 7);
        run_txn(0, 3, 0);
        new_req(0, 1'b0, 32'h8000_6000, 3);
        run_txn(0, -1, -1);
        idle_check();

        // Both ports keep requesting for four transactions.
        for (int t = 0; t < 4; t++) begin
            if (!pend[0]) new_req(0, 1'($urandom), $urandom, $urandom_range(0, 3));
            if (!pend[1]) new_req(1, 1'($urandom), $urandom, $urandom_range(0, 3));
            run_txn(0, -1, -1);
        end
        while (pend != 2'b00) run_txn(0, -1, -1);
        idle_check();

        // Random traffic.
        for (int t = 0; t < 40; t++) begin
            for (int p = 0; p < 2; p++)
                if (!pend[p] && $urandom_range(0, 1) == 1)
                    new_req(p, 1'($urandom), $urandom, $urandom_range(0, 7));
            if (pend == 2'b00) new_req($urandom_range(0, 1), 1'($urandom), $urandom, $urandom_range(0, 7));
            run_txn(1'($urandom_range(0, 1)), -1, -1);
            if (pend == 2'b00) idle_check();
        end
        while (pend != 2'b00) run_txn(0, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ysyx_22050133_axi_arbiter.md
YSYX_22050133_AXI_ARBITER -- requirements
Module: ysyx_22050133_axi_arbiter

Interface
- REQ-001 SHALL have parameter DATA_WIDTH, default 64: data bus width.
- REQ-002 SHALL have parameter ADDR_WIDTH, default 32: address width.
- REQ-003 SHALL have port clk, input, 1: the only clock.
- REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
- REQ-005 SHALL have port s_addr_valid_i, input, 2: per-requester request valid. Bit 0 is the icache; bit 1 is the dcache.
- REQ-006 SHALL have port s_addr_ready_o, output, 2: per-requester request accept.
- REQ-007 SHALL have port s_addr_i, input, 2*ADDR_WIDTH: request addresses. Port 0 occupies the low slice.
- REQ-008 SHALL have port s_cmd_i, input, 2*12: per-requester command {we[11], size[10:8], len[7:0]}.
- REQ-009 SHALL have port s_w_valid_i, input, 2: write-beat valid.
- REQ-010 SHALL have port s_w_ready_o, output, 2: write-beat ready.
- REQ-011 SHALL have port s_w_data_i, input, 2*DATA_WIDTH: write data.
- REQ-012 SHALL have port s_r_valid_o, output, 2: read-beat valid.
- REQ-013 SHALL have port s_r_ready_i, input, 2: read-beat ready.
- REQ-014 SHALL have port s_r_data_o, output, DATA_WIDTH: read data, broadcast to both requesters.
- REQ-015 SHALL have port m_addr_valid_o, output, 1: downstream request valid.
- REQ-016 SHALL have port m_addr_ready_i, input, 1: downstream request accept.
- REQ-017 SHALL have port m_addr_o, output, ADDR_WIDTH: downstream address.
- REQ-018 SHALL have port m_cmd_o, output, 12: downstream command, same packing as s_cmd_i.
- REQ-019 SHALL have port m_w_valid_o, output, 1: downstream write-beat valid.
- REQ-020 SHALL have port m_w_ready_i, input, 1: downstream write-beat ready.
- REQ-021 SHALL have port m_w_data_o, output, DATA_WIDTH: downstream write data.
- REQ-022 SHALL have port m_r_valid_i, input, 1: downstream read-beat valid.
- REQ-023 SHALL have port m_r_ready_o, output, 1: downstream read-beat ready.
- REQ-024 SHALL have port m_r_data_i, input, DATA_WIDTH: downstream read data.

Function
- REQ-025 SHALL implement a three-state FSM:
  - IDLE -> ADDR on grant.
  - ADDR -> DATA when m_addr_valid_o & m_addr_ready_i.
  - DATA -> IDLE on the final beat.
- REQ-026 In IDLE, with any s_addr_valid_i set, SHALL:
  - pick a winner;
  - pulse s_addr_ready_o[winner] high for exactly one cycle;
  - latch the winner's address, command and the grant index.
- REQ-027 Without the Configuration macro, SHALL use fixed priority: port 1 wins when both ports request.
- REQ-028 SHALL drive m_addr_valid_o high from the cycle after the grant, i.e. a request seen at cycle t gives m_addr_valid_o=1 at t+1.
- REQ-029 SHALL hold m_addr_o and m_cmd_o stable while m_addr_valid_o=1.
- REQ-030 On the address handshake, SHALL load an 8-bit beat counter with len; the transaction is len+1 beats.
- REQ-031 In DATA with we=1, SHALL route the write channel combinationally:
  - m_w_valid_o = s_w_valid_i[gnt];
  - s_w_ready_o[gnt] = m_w_ready_i;
  - m_w_data_o = granted slice.
- REQ-032 In DATA with we=0, SHALL route the read channel combinationally:
  - s_r_valid_o[gnt] = m_r_valid_i;
  - m_r_ready_o = s_r_ready_i[gnt].
- REQ-033 SHALL decrement the counter on each beat handshake, and SHALL return to IDLE on the handshake where the counter is 0.
- REQ-034 SHALL hold the non-granted port's s_addr_ready_o, s_w_ready_o and s_r_valid_o at 0 at all times.
- REQ-035 SHALL NOT change the grant mid-transaction.
- REQ-036 SHALL allow a new grant no earlier than the cycle after returning to IDLE (minimum one idle cycle between transactions).
- REQ-037 A requester deasserting valid after acceptance SHALL NOT affect the latched transaction.
- REQ-038 SHALL keep the read channel inactive (m_r_ready_o=0) during write transactions, and the write channel inactive (m_w_valid_o=0) during read transactions.

Reset
- REQ-039 While rst=1, SHALL force:
  - state IDLE, grant 0, counter 0;
  - all *_valid_o and *_ready_o outputs 0;
  - m_addr_o, m_cmd_o and s_r_data_o to 0.
- REQ-040 Reset asserted mid-transaction SHALL abandon the transaction, and no further beats SHALL be forwarded.

Configuration
- REQ-041 With YSYX_22050133_ARB_RR_EN defined, SHALL use round-robin arbitration: on a simultaneous request, the port not granted last wins. The last-grant register resets to port 1, so port 0 wins the first tie.
- REQ-042 With YSYX_22050133_ARB_RR_EN undefined, SHALL use fixed priority per REQ-027, and no last-grant register SHALL exist.

Structure
- REQ-043 The state encoding, command field bit positions, and the size/burst encodings (AXI_SIZE_BYTES_*) SHALL reside in the shared ysyx_22050133 defines package.
- REQ-044 The winner-select logic SHALL be one sub-module, ysyx_22050133_arb_pick: inputs are the request vector and the last grant; output is the winner index.

Verification
- REQ-045 Port 0 read, addr 0x80000040, len 7 -> one m_addr_valid_o with addr 0x80000040; 8 beats returned on s_r_valid_o[0]; s_r_valid_o[1]=0 throughout.
- REQ-046 Both ports request in the same cycle (fixed priority) -> port 1 granted first; port 0 granted after port 1's last beat plus one idle cycle.
- REQ-047 Port 1 write, len 7, with m_w_ready_i toggling every other cycle -> exactly 8 beats forwarded in order; FSM returns to IDLE after the 8th handshake.
- REQ-048 rst pulsed during beat 3 of an 8-beat read -> all outputs are 0 the next cycle; a subsequent port 0 request is granted normally.
- REQ-049 With YSYX_22050133_ARB_RR_EN defined, both ports request continuously for 4 transactions -> grant order 0,1,0,1.
- REQ-050 m_addr_ready_i held low for 5 cycles -> m_addr_o and m_cmd_o are stable and m_addr_valid_o stays high until accepted.
